// File: rtl/truth_table_sweeper_pkg.sv
// ============================================================================
// Module : tts_pkg
// Brief  : Shared state encoding and table-depth helpers for the truth-table sweeper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tts_pkg;

    localparam int c_MAX_IN_WIDTH = 5;
    localparam int c_TTS_DEPTH    = 2 ** c_MAX_IN_WIDTH;

    typedef logic [2:0] state_t;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_APPLY  = 3'd1;
    localparam logic [2:0] c_ST_SETTLE = 3'd2;
    localparam logic [2:0] c_ST_SAMPLE = 3'd3;
    localparam logic [2:0] c_ST_STORE  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    function automatic int tts_depth(input int in_width);
        return 2 ** in_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_bit_synchronizer.sv
// ============================================================================
// Module : bit_synchronizer
// Brief  : Two-flop synchronizer for a single asynchronous bit, reset to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module : truth_table_sweeper
// Brief  : Sweeps every input vector of an asynchronous DUT and captures its
//          settled truth table together with a per-vector instability mask.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int IN_WIDTH      = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [IN_WIDTH-1:0]      dut_in,
    input  logic                     dut_out,
    output logic                     busy,
    output logic                     done,
    output logic [2**IN_WIDTH-1:0]   truth_table,
    output logic [2**IN_WIDTH-1:0]   unstable_mask
);

    localparam int c_DEPTH   = tts_depth(IN_WIDTH);
    localparam int c_CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_SAMPLE_LAST = c_CNT_W'(SAMPLES - 1);
    localparam logic [IN_WIDTH:0]   c_LAST_VEC    = (IN_WIDTH + 1)'(c_DEPTH - 1);

    state_t              r_state;
    logic [IN_WIDTH:0]   r_vec;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_ref;
    logic                r_last;
    logic                r_flag;
    logic                w_sample;

    bit_synchronizer u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (dut_out),
        .o_q (w_sample)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_vec         <= '0;
            r_cnt         <= '0;
            r_ref         <= 1'b0;
            r_last        <= 1'b0;
            r_flag        <= 1'b0;
            dut_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            truth_table   <= '0;
            unstable_mask <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        truth_table   <= '0;
                        unstable_mask <= '0;
                        r_vec         <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        r_state       <= c_ST_APPLY;
                    end
                end
                c_ST_APPLY: begin
                    dut_in  <= r_vec[IN_WIDTH-1:0];
                    r_cnt   <= '0;
                    r_state <= c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_SAMPLE: begin
                    // First sample is the reference; later ones only raise the sticky flag
                    if (r_cnt == '0) begin
                        r_ref  <= w_sample;
                        r_flag <= 1'b0;
                    end else if (w_sample != r_ref) begin
                        r_flag <= 1'b1;
                    end
                    r_last <= w_sample;
                    if (r_cnt == c_SAMPLE_LAST) begin
                        r_state <= c_ST_STORE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_STORE: begin
                    truth_table[r_vec[IN_WIDTH-1:0]]   <= r_last;
                    unstable_mask[r_vec[IN_WIDTH-1:0]] <= r_flag;
                    if (r_vec == c_LAST_VEC) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_vec   <= r_vec + 1'b1;
                        r_state <= c_ST_APPLY;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
